// File: rtl/msu_data_fetch.sv
// MSU data prefetcher: byte-serial MSU reads served from a FIFO of 64-bit DDR burst words.
// Define MSU_FETCH_STATS_EN to add the underrun_cnt output and its saturating counter.
module msu_data_fetch #(
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter logic [28:0] DDR_BASE   = 29'h0C00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic        data_seek,
   input  logic        data_req,
   output logic [7:0]  data,
   output logic        data_ack,
   output logic [28:0] ddr_addr,
   output logic        ddr_req,
   input  logic        ddr_ack,
   input  logic [63:0] ddr_di,
   output logic        busy
`ifdef MSU_FETCH_STATS_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned CntW  = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e                state_q;
   logic [28:0]           addr_q;
   logic [28:0]           reseek_q;
   logic                  req_q;
   logic                  discard_q;
   logic                  active_q;
   logic                  busy_q;

   logic [63:0]           mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [CntW-1:0]       count_q;
   logic [3:0]            pending_q;
   logic [2:0]            offset_q;
   logic [7:0]            data_q;
   logic                  ack_q;

   logic [28:0]           seek_addr;
   logic                  ddr_done;
   logic                  push;
   logic                  fifo_empty;
   logic                  room;
   logic                  demand;
   logic                  serve;
   logic                  pop;
   logic                  inc;
   logic [63:0]           head;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^data_addr[31:29];

   assign seek_addr  = DDR_BASE + {data_addr[28:3], 3'b000};
   assign ddr_done   = req_q && ddr_ack;
   // A word returning alongside a seek, or flagged stale by an earlier seek, is dropped.
   assign push       = ddr_done && !discard_q && !data_seek;
   assign fifo_empty = (count_q == '0);
   assign room       = (count_q < CntW'(Depth));
   assign demand     = (pending_q != 4'd0) || data_req;
   assign serve      = demand && !fifo_empty && !data_seek;
   assign pop        = serve && (offset_q == 3'd7);
   assign inc        = data_req && ((pending_q != 4'd15) || serve);
   assign head       = mem_q[rd_ptr_q];

   // Fetch FSM; at most one DDR request outstanding.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         req_q     <= 1'b0;
         addr_q    <= DDR_BASE;
         reseek_q  <= DDR_BASE;
         discard_q <= 1'b0;
         active_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (data_seek) begin
            active_q <= 1'b1;
            busy_q   <= 1'b1;
         end else if (push) begin
            busy_q <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               if (data_seek) begin
                  addr_q  <= seek_addr;
                  state_q <= StIssue;
                  req_q   <= 1'b1;
               end else if (active_q && room) begin
                  state_q <= StIssue;
                  req_q   <= 1'b1;
               end
            end
            StIssue, StWait: begin
               if (ddr_done) begin
                  req_q     <= 1'b0;
                  state_q   <= StIdle;
                  discard_q <= 1'b0;
                  if (data_seek) begin
                     addr_q <= seek_addr;
                  end else if (discard_q) begin
                     addr_q <= reseek_q;
                  end else begin
                     addr_q <= addr_q + 29'd8;
                  end
               end else begin
                  state_q <= StWait;
                  // ddr_addr must hold while the request is up; park the new target.
                  if (data_seek) begin
                     discard_q <= 1'b1;
                     reseek_q  <= seek_addr;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= ddr_di;
      end
   end

   // FIFO bookkeeping and the byte serve path.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= 4'd0;
         offset_q  <= 3'd0;
         data_q    <= 8'h00;
         ack_q     <= 1'b0;
      end else begin
         ack_q <= serve;
         if (serve) begin
            data_q <= head[{offset_q, 3'b000} +: 8];
         end
         if (data_seek) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            offset_q  <= data_addr[2:0];
            pending_q <= {3'b000, data_req};
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (serve) begin
               offset_q <= offset_q + 3'd1;
            end
            pending_q <= pending_q + 4'(inc) - 4'(serve);
         end
      end
   end

`ifdef MSU_FETCH_STATS_EN
   logic [15:0] urun_q;

   always_ff @(posedge clk) begin
      if (reset || data_seek) begin
         urun_q <= 16'h0000;
      end else if ((pending_q != 4'd0) && fifo_empty && !busy_q && (urun_q != 16'hFFFF)) begin
         urun_q <= urun_q + 16'd1;
      end
   end

   assign underrun_cnt = urun_q;
`endif

   assign data     = data_q;
   assign data_ack = ack_q;
   assign ddr_addr = addr_q;
   assign ddr_req  = req_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_msu_data_fetch.sv
// Scoreboard bench for msu_data_fetch: expected bytes queued at each data_req, popped on data_ack.
module tb_msu_data_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_addr;
   logic        data_seek;
   logic        data_req;
   logic [7:0]  data;
   logic        data_ack;
   logic [28:0] ddr_addr;
   logic        ddr_req;
   logic        ddr_ack;
   logic [63:0] ddr_di;
   logic        busy;
`ifdef MSU_FETCH_STATS_EN
   logic [15:0] underrun_cnt;
`endif

   always #5 clk = ~clk;

   msu_data_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .data_addr (data_addr),
      .data_seek (data_seek),
      .data_req  (data_req),
      .data      (data),
      .data_ack  (data_ack),
      .ddr_addr  (ddr_addr),
      .ddr_req   (ddr_req),
      .ddr_ack   (ddr_ack),
      .ddr_di    (ddr_di),
      .busy      (busy)
`ifdef MSU_FETCH_STATS_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb [$];
   int         ack_log [$];
   int         cyc = 0;
   int         issue_cnt = 0;
   logic       prev_req = 1'b0;
   int         ddr_lat = 0;
   bit         ddr_hold = 1'b0;

   function automatic logic [63:0] word_at(input logic [28:0] a);
      case (a)
         29'h0C00_0000: word_at = 64'hDEAD_BEEF_CAFE_F00D;
         29'h0C00_0008: word_at = 64'h8877_6655_4433_2211;
         29'h0C00_0010: word_at = 64'h0807_0605_0403_0201;
         29'h0C00_0100: word_at = 64'hF8F7_F6F5_F4F3_F2F1;
         29'h0C00_0200: word_at = 64'hA7A6_A5A4_A3A2_A1A0;
         29'h0C00_0300: word_at = 64'h5857_5655_5453_5251;
         default:       word_at = 64'hEEEE_EEEE_EEEE_EEEE;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // DDR responder: acks ddr_lat cycles after seeing ddr_req, unless held off.
   initial begin : ddr_model
      int wcnt;
      wcnt    = 0;
      ddr_ack = 1'b0;
      ddr_di  = '0;
      forever begin
         @(negedge clk);
         ddr_ack = 1'b0;
         if (ddr_req && !ddr_hold) begin
            if (wcnt >= ddr_lat) begin
               ddr_ack = 1'b1;
               ddr_di  = word_at(ddr_addr);
               wcnt    = 0;
            end else begin
               wcnt++;
            end
         end else if (!ddr_req) begin
            wcnt = 0;
         end
      end
   end

   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (ddr_req && !prev_req) issue_cnt++;
         prev_req = ddr_req;
         if (data_ack) begin
            ack_log.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_extra: got ack with data %0h want no ack", data);
            end else begin
               e = sb.pop_front();
               chk("data", {56'h0, data}, {56'h0, e});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic req(input logic [7:0] e);
      data_req = 1'b1;
      sb.push_back(e);
      tick();
      data_req = 1'b0;
   endtask

   task automatic seek(input logic [31:0] a, input bit with_req, input logic [7:0] e);
      data_addr = a;
      data_seek = 1'b1;
      data_req  = with_req;
      if (with_req) sb.push_back(e);
      tick();
      data_seek = 1'b0;
      data_req  = 1'b0;
   endtask

   task automatic wait_req(input logic lvl, input int bound, input string name);
      int n = 0;
      while (ddr_req !== lvl && n < bound) begin
         tick();
         n++;
      end
      chk(name, {63'h0, ddr_req}, {63'h0, lvl});
   endtask

   task automatic wait_req_at(input logic [28:0] a, input int bound, input string name);
      int n = 0;
      while (!(ddr_req === 1'b1 && ddr_addr === a) && n < bound) begin
         tick();
         n++;
      end
      chk(name, {35'h0, ddr_addr}, {35'h0, a});
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < bound) begin
         tick();
         n++;
      end
      chk(name, {63'h0, busy}, 64'h0);
   endtask

   task automatic drain(input int bound, input string name);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      chk(name, 64'(sb.size()), 64'h0);
   endtask

   initial begin : stim
      reset     = 1'b1;
      data_addr = '0;
      data_seek = 1'b0;
      data_req  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_data", {56'h0, data}, 64'h0);
      chk("rst_ack", {63'h0, data_ack}, 64'h0);
      chk("rst_ddr_req", {63'h0, ddr_req}, 64'h0);
      chk("rst_ddr_addr", {35'h0, ddr_addr}, 64'h0C00_0000);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      repeat (5) tick();
      chk("no_fetch_before_seek", {63'h0, ddr_req}, 64'h0);

      // Aligned seek, 5-cycle DDR latency.
      ddr_lat = 5;
      seek(32'h10, 1'b0, 8'h00);
      chk("seek1_addr", {35'h0, ddr_addr}, 64'h0C00_0010);
      chk("seek1_busy", {63'h0, busy}, 64'h1);
      chk("seek1_req", {63'h0, ddr_req}, 64'h1);
      wait_idle(30, "seek1_busy_fall");
      for (int i = 1; i <= 8; i++) req(8'(i));
      drain(30, "drain1");

      // Unaligned seek crosses into the next word.
      seek(32'h0D, 1'b0, 8'h00);
      wait_idle(40, "seek2_busy_fall");
      req(8'h66);
      req(8'h77);
      req(8'h88);
      req(8'h01);
      drain(60, "drain2");

      // Seek while a request is outstanding; coincident data_req is post-seek.
      ddr_lat = 10;
      seek(32'h00, 1'b0, 8'h00);
      wait_req_at(29'h0C00_0000, 60, "seek3_first_addr");
      repeat (2) tick();
      seek(32'h100, 1'b1, 8'hF1);
      wait_req(1'b0, 30, "stale_done");
      chk("busy_after_stale", {63'h0, busy}, 64'h1);
      wait_req(1'b1, 10, "reissue");
      chk("reissue_addr", {35'h0, ddr_addr}, 64'h0C00_0100);
      req(8'hF2);
      drain(40, "drain3");

      // Underrun: DDR held off with 3 bytes pending.
      ddr_hold = 1'b1;
      ddr_lat  = 2;
      seek(32'h200, 1'b0, 8'h00);
      ack_log.delete();
      req(8'hA0);
      req(8'hA1);
      req(8'hA2);
      repeat (20) tick();
      chk("hold_no_ack", 64'(ack_log.size()), 64'h0);
      chk("hold_req", {63'h0, ddr_req}, 64'h1);
      chk("hold_busy", {63'h0, busy}, 64'h1);
      ddr_hold = 1'b0;
      drain(30, "drain4");
      chk("underrun_acks", 64'(ack_log.size()), 64'h3);
      if (ack_log.size() == 3) begin
         chk("underrun_gap1", 64'(ack_log[1] - ack_log[0]), 64'h1);
         chk("underrun_gap2", 64'(ack_log[2] - ack_log[1]), 64'h1);
      end
`ifdef MSU_FETCH_STATS_EN
      chk("underrun_cnt", {48'h0, underrun_cnt}, 64'h0);
`endif

      // FIFO full: zero-latency DDR, 8 issues then stop.
      ddr_lat   = 0;
      issue_cnt = 0;
      seek(32'h300, 1'b0, 8'h00);
      repeat (40) tick();
      chk("full_issues", 64'(issue_cnt), 64'h8);
      chk("full_req_low", {63'h0, ddr_req}, 64'h0);
      req(8'h51);
      repeat (10) tick();
      chk("one_byte_no_issue", 64'(issue_cnt), 64'h8);
      for (int i = 2; i <= 8; i++) req(8'(8'h50 + i));
      repeat (10) tick();
      chk("pop_one_issue", 64'(issue_cnt), 64'h9);
      drain(10, "drain5");

      // Reset in the middle of a DDR request.
      ddr_lat = 10;
      seek(32'h400, 1'b0, 8'h00);
      wait_req_at(29'h0C00_0400, 40, "seek6_addr");
      reset = 1'b1;
      tick();
      chk("midrst_req", {63'h0, ddr_req}, 64'h0);
      chk("midrst_ack", {63'h0, data_ack}, 64'h0);
      chk("midrst_addr", {35'h0, ddr_addr}, 64'h0C00_0000);
      chk("midrst_busy", {63'h0, busy}, 64'h0);
      chk("midrst_data", {56'h0, data}, 64'h0);
      reset     = 1'b0;
      issue_cnt = 0;
      repeat (20) tick();
      chk("no_fetch_after_rst", 64'(issue_cnt), 64'h0);
      chk("req_low_after_rst", {63'h0, ddr_req}, 64'h0);
      drain(5, "drain_final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
